// File: rtl/mgt01_ireg_ctx_sequencer.sv
// Purpose: interrupt context save/restore of x1..x(REG_COUNT-1) between the integer register file and data memory.
// Latency: save = (REG_COUNT-1) granted store cycles + 1 DONE cycle; restore = 2 cycles/register minimum + 1 DONE cycle.
// Backpressure: mem_gnt_i low stalls with address/data held; restore waits indefinitely for mem_rvalid_i.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   save_req_i, restore_req_i    start requests, sampled only in IDLE (save wins when both are high)
//   base_addr_i                  save-area byte base, latched at start and word-aligned
//   busy_o, done_o               busy while not IDLE; one-cycle completion pulse
//   rf_raddr_o / rf_rdata_i      register-file read port (combinational read data)
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write port
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i  data-memory port
module mgt01_ireg_ctx_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         save_req_i,
   input  logic                         restore_req_i,
   input  logic [31:0]                  base_addr_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(REG_COUNT)-1:0] rf_raddr_o,
   input  logic [DATA_WIDTH-1:0]        rf_rdata_i,
   output logic                         rf_we_o,
   output logic [$clog2(REG_COUNT)-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0]        rf_wdata_o,
   output logic                         mem_req_o,
   output logic                         mem_we_o,
   output logic [31:0]                  mem_addr_o,
   output logic [DATA_WIDTH-1:0]        mem_wdata_o,
   input  logic                         mem_gnt_i,
   input  logic                         mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

   localparam int                IDX_W    = $clog2(REG_COUNT);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REG_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_RESTORE_REQ,
      S_RESTORE_WAIT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   // Address of the current register, advanced by 4 alongside idx_q so no
   // multiplier is needed; 32-bit overflow gives the required wrap-around.
   logic [31:0]       addr_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (save_req_i || restore_req_i) begin
                  state_q <= save_req_i ? S_SAVE : S_RESTORE_REQ;
                  idx_q   <= IDX_W'(1);
                  addr_q  <= base_addr_i & 32'hFFFF_FFFC;
               end
            end
            S_SAVE: begin
               if (mem_gnt_i) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q  <= idx_q + IDX_W'(1);
                     addr_q <= addr_q + 32'd4;
                  end
               end
            end
            S_RESTORE_REQ: begin
               if (mem_gnt_i) begin
                  state_q <= S_RESTORE_WAIT;
               end
            end
            S_RESTORE_WAIT: begin
               if (mem_rvalid_i) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_RESTORE_REQ;
                     idx_q   <= idx_q + IDX_W'(1);
                     addr_q  <= addr_q + 32'd4;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode directly from state so an asynchronous reset clears them
   // immediately. Store data and register writes are combinational pass-throughs
   // because the register-file read and the load return are same-cycle.
   logic save_st;
   logic rreq_st;
   logic wr_fire;

   assign save_st = (state_q == S_SAVE);
   assign rreq_st = (state_q == S_RESTORE_REQ);
   assign wr_fire = (state_q == S_RESTORE_WAIT) && mem_rvalid_i;

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign mem_req_o   = save_st || rreq_st;
   assign mem_we_o    = save_st;
   assign mem_addr_o  = mem_req_o ? addr_q : '0;
   assign rf_raddr_o  = save_st ? idx_q : '0;
   assign mem_wdata_o = save_st ? rf_rdata_i : '0;
   assign rf_we_o     = wr_fire;
   assign rf_waddr_o  = wr_fire ? idx_q : '0;
   assign rf_wdata_o  = wr_fire ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mgt01_ireg_ctx_sequencer.sv
// Purpose: self-checking bench for mgt01_ireg_ctx_sequencer with register-file and memory models.
// Latency: cycle offsets measured from the first busy cycle after the accepting edge.
// Backpressure: memory responder can withhold or randomise grants and delay load data.
module tb_mgt01_ireg_ctx_sequencer;

   logic        clk_i;
   logic        rst_n_i;
   logic        save_req_i;
   logic        restore_req_i;
   logic [31:0] base_addr_i;
   logic        busy_o;
   logic        done_o;
   logic [4:0]  rf_raddr_o;
   logic [31:0] rf_rdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   mgt01_ireg_ctx_sequencer dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .save_req_i    (save_req_i),
      .restore_req_i (restore_req_i),
      .base_addr_i   (base_addr_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .rf_raddr_o    (rf_raddr_o),
      .rf_rdata_i    (rf_rdata_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Register file and memory models.
   logic [31:0] tb_rf [32];
   logic [31:0] mem_model [logic [31:0]];
   assign rf_rdata_i = tb_rf[rf_raddr_o];

   // Responder knobs.
   bit          gnt_rand    = 0;
   int          rv_lat      = 1;
   logic [31:0] hold_addr   = 32'h0;
   int          hold_left   = 0;
   int          suppress_at = 0;
   bit          inject_rv   = 0;

   // Observation logs.
   logic [31:0] st_addr [$];
   logic [31:0] st_data [$];
   logic [31:0] ld_addr [$];
   logic [31:0] rq_addr [$];
   logic [31:0] rq_data [$];
   bit          rq_we   [$];
   logic [4:0]  rfw_addr [$];
   logic [31:0] rfw_data [$];
   int          done_cnt  = 0;
   int          done_cyc  = 0;
   int          x0_writes = 0;
   int          start_cyc = 0;

   bit          pend      = 0;
   int          pend_cnt  = 0;
   logic [31:0] pend_data = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Memory responder: drives inputs on the falling edge, then samples the
   // settled DUT outputs 1 time unit later and logs what the next edge commits.
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      forever begin
         @(negedge clk_i);
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
         if (!rst_n_i) pend = 0;
         if (inject_rv) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h0BAD_0BAD;
            inject_rv    = 0;
         end else if (pend) begin
            if (pend_cnt <= 1) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = pend_data;
               pend         = 0;
            end else begin
               pend_cnt--;
            end
         end
         mem_gnt_i = 1'b0;
         if (mem_req_o) begin
            if (hold_left > 0 && mem_addr_o == hold_addr) hold_left--;
            else if (gnt_rand) mem_gnt_i = 1'($urandom_range(0, 1));
            else mem_gnt_i = 1'b1;
         end
         #1;
         if (mem_req_o) begin
            rq_addr.push_back(mem_addr_o);
            rq_data.push_back(mem_wdata_o);
            rq_we.push_back(mem_we_o);
            if (mem_gnt_i) begin
               if (mem_we_o) begin
                  st_addr.push_back(mem_addr_o);
                  st_data.push_back(mem_wdata_o);
                  mem_model[mem_addr_o] = mem_wdata_o;
               end else begin
                  ld_addr.push_back(mem_addr_o);
                  pend      = 1;
                  pend_cnt  = rv_lat;
                  pend_data = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
                  if (suppress_at > 0 && ld_addr.size() == suppress_at) pend = 0;
               end
            end
         end
         if (rf_we_o) begin
            rfw_addr.push_back(rf_waddr_o);
            rfw_data.push_back(rf_wdata_o);
            if (rf_waddr_o == 5'd0) x0_writes++;
            else tb_rf[rf_waddr_o] = rf_wdata_o;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
      return (base & 32'hFFFF_FFFC) + 32'(4 * (i - 1));
   endfunction

   task automatic clear_logs();
      st_addr.delete(); st_data.delete(); ld_addr.delete();
      rq_addr.delete(); rq_data.delete(); rq_we.delete();
      rfw_addr.delete(); rfw_data.delete();
      done_cnt = 0; x0_writes = 0;
   endtask

   // Raise the request(s) for one edge; start_cyc marks the first busy cycle.
   task automatic start(input bit sv, input bit rs, input logic [31:0] base);
      @(negedge clk_i);
      save_req_i    = sv;
      restore_req_i = rs;
      base_addr_i   = base;
      @(negedge clk_i);
      save_req_i    = 1'b0;
      restore_req_i = 1'b0;
      start_cyc     = cyc;
      #2;
      checks++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b1)
         begin failures++; $display("FAIL start_busy busy=%b req=%b exp 1/1", busy_o, mem_req_o); end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk_i); #2;
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         failures++; $display("FAIL done_timeout budget=%0d", budget);
      end else begin
         @(negedge clk_i); #2;
         checks++;
         if (busy_o !== 1'b0 || done_o !== 1'b0)
            begin failures++; $display("FAIL idle_after_done busy=%b done=%b exp 0/0", busy_o, done_o); end
      end
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; save_req_i = 1'b0; restore_req_i = 1'b0; base_addr_i = 32'h0;
      repeat (3) @(negedge clk_i);
      #2;
      checks++;
      if ({busy_o, done_o, mem_req_o, mem_we_o, rf_we_o} !== 5'b0)
         begin failures++; $display("FAIL reset_ctrl got=%b exp 00000", {busy_o, done_o, mem_req_o, mem_we_o, rf_we_o}); end
      checks++;
      if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || rf_wdata_o !== 32'h0 || rf_raddr_o !== 5'h0 || rf_waddr_o !== 5'h0)
         begin failures++; $display("FAIL reset_data addr=%h wdata=%h rfwd=%h exp 0", mem_addr_o, mem_wdata_o, rf_wdata_o); end
      rst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_save();
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'hA500_0000 + 32'(i);
      gnt_rand = 0; clear_logs();
      start(1'b1, 1'b0, 32'h0000_1000);
      wait_done(200);
      checks++;
      if (st_addr.size() != 31) begin failures++; $display("FAIL save_count got=%0d exp 31", st_addr.size()); end
      for (int i = 1; i < 32 && i <= st_addr.size(); i++) begin
         checks++;
         if (st_addr[i-1] !== 32'h0000_1000 + 32'(4*(i-1)) || st_data[i-1] !== 32'hA500_0000 + 32'(i))
            begin failures++; $display("FAIL save_word%0d addr=%h data=%h", i, st_addr[i-1], st_data[i-1]); end
      end
      checks++;
      if (done_cyc - start_cyc != 31) begin failures++; $display("FAIL save_latency got=%0d exp 31", done_cyc - start_cyc); end
      checks++;
      if (rfw_addr.size() != 0 || ld_addr.size() != 0)
         begin failures++; $display("FAIL save_no_rf_we rfw=%0d loads=%0d exp 0", rfw_addr.size(), ld_addr.size()); end
   endtask

   task automatic test_restore();
      mem_model.delete();
      for (int k = 0; k < 31; k++) mem_model[32'h1000 + 32'(4*k)] = 32'h5A00_0000 + 32'(k);
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'hDEAD_0000;
      gnt_rand = 0; rv_lat = 1; clear_logs();
      start(1'b0, 1'b1, 32'h0000_1000);
      wait_done(300);
      checks++;
      if (rfw_addr.size() != 31) begin failures++; $display("FAIL restore_count got=%0d exp 31", rfw_addr.size()); end
      for (int i = 1; i < 32 && i <= rfw_addr.size(); i++) begin
         checks++;
         if (rfw_addr[i-1] !== 5'(i) || rfw_data[i-1] !== 32'h5A00_0000 + 32'(i-1))
            begin failures++; $display("FAIL restore_reg%0d waddr=%0d data=%h", i, rfw_addr[i-1], rfw_data[i-1]); end
      end
      checks++;
      if (x0_writes != 0 || tb_rf[0] !== 32'hDEAD_0000)
         begin failures++; $display("FAIL restore_x0 writes=%0d x0=%h exp 0/dead0000", x0_writes, tb_rf[0]); end
      checks++;
      if (done_cyc - start_cyc != 62) begin failures++; $display("FAIL restore_latency got=%0d exp 62", done_cyc - start_cyc); end
      checks++;
      if (st_addr.size() != 0) begin failures++; $display("FAIL restore_no_store got=%0d exp 0", st_addr.size()); end
   endtask

   task automatic test_stall();
      int hits = 0;
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'hA500_0000 + 32'(i);
      gnt_rand = 0; hold_addr = 32'h1010; hold_left = 3; clear_logs();
      start(1'b1, 1'b0, 32'h0000_1000);
      wait_done(200);
      for (int j = 0; j < rq_addr.size(); j++) begin
         if (rq_addr[j] == 32'h1010) begin
            hits++;
            checks++;
            if (rq_data[j] !== 32'hA500_0005 || rq_we[j] !== 1'b1)
               begin failures++; $display("FAIL stall_hold data=%h we=%b exp a5000005/1", rq_data[j], rq_we[j]); end
         end
      end
      checks++;
      if (hits != 4) begin failures++; $display("FAIL stall_cycles got=%0d exp 4", hits); end
      checks++;
      if (st_addr.size() != 31) begin failures++; $display("FAIL stall_count got=%0d exp 31", st_addr.size()); end
      checks++;
      if (done_cyc - start_cyc != 34) begin failures++; $display("FAIL stall_latency got=%0d exp 34", done_cyc - start_cyc); end
   endtask

   task automatic test_both_req();
      gnt_rand = 0; clear_logs();
      start(1'b1, 1'b1, 32'h0000_3000);
      repeat (5) @(negedge clk_i);
      restore_req_i = 1'b1;
      @(negedge clk_i);
      restore_req_i = 1'b0;
      wait_done(200);
      repeat (10) @(negedge clk_i);
      #2;
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL both_done_pulses got=%0d exp 1", done_cnt); end
      checks++;
      if (ld_addr.size() != 0 || st_addr.size() != 31)
         begin failures++; $display("FAIL both_only_save loads=%0d stores=%0d exp 0/31", ld_addr.size(), st_addr.size()); end
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL both_not_queued busy=%b exp 0", busy_o); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 32; i++) tb_rf[i] = $urandom;
      gnt_rand = 0; clear_logs();
      start(1'b1, 1'b0, 32'hFFFF_FFF3);
      wait_done(200);
      checks++;
      if (st_addr.size() != 31) begin failures++; $display("FAIL wrap_count got=%0d exp 31", st_addr.size()); end
      else begin
         checks++;
         if (st_addr[0] !== 32'hFFFF_FFF0) begin failures++; $display("FAIL wrap_first got=%h exp fffffff0", st_addr[0]); end
         checks++;
         if (st_addr[4] !== 32'h0000_0000) begin failures++; $display("FAIL wrap_idx5 got=%h exp 00000000", st_addr[4]); end
         checks++;
         if (st_addr[30] !== 32'h0000_0068 || st_data[30] !== tb_rf[31])
            begin failures++; $display("FAIL wrap_last addr=%h data=%h exp 00000068/%h", st_addr[30], st_data[30], tb_rf[31]); end
      end
   endtask

   task automatic test_roundtrip_random();
      logic [31:0] snap [32];
      logic [31:0] base;
      for (int it = 0; it < 3; it++) begin
         base = $urandom;
         mem_model.delete();
         for (int i = 0; i < 32; i++) begin tb_rf[i] = $urandom; snap[i] = tb_rf[i]; end
         gnt_rand = 1; rv_lat = $urandom_range(1, 3); clear_logs();
         start(1'b1, 1'b0, base);
         wait_done(2000);
         checks++;
         if (st_addr.size() != 31) begin failures++; $display("FAIL rt%0d_save_count got=%0d exp 31", it, st_addr.size()); end
         for (int i = 1; i < 32 && i <= st_addr.size(); i++) begin
            checks++;
            if (st_addr[i-1] !== exp_addr(base, i) || st_data[i-1] !== snap[i])
               begin failures++; $display("FAIL rt%0d_store%0d addr=%h data=%h exp %h/%h", it, i, st_addr[i-1], st_data[i-1], exp_addr(base, i), snap[i]); end
         end
         for (int i = 1; i < 32; i++) tb_rf[i] = ~snap[i];
         clear_logs();
         start(1'b0, 1'b1, base);
         wait_done(4000);
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (tb_rf[i] !== snap[i])
               begin failures++; $display("FAIL rt%0d_reg%0d got=%h exp %h", it, i, tb_rf[i], snap[i]); end
         end
      end
      gnt_rand = 0; rv_lat = 1;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      mem_model.delete();
      for (int k = 0; k < 31; k++) mem_model[32'h1000 + 32'(4*k)] = 32'h5A00_0000 + 32'(k);
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'h1111_0000 + 32'(i);
      suppress_at = 10; clear_logs();
      start(1'b0, 1'b1, 32'h0000_1000);
      while (ld_addr.size() < 10 && n < 200) begin @(negedge clk_i); #2; n++; end
      checks++;
      if (ld_addr.size() != 10) begin failures++; $display("FAIL rstmid_reach got=%0d exp 10", ld_addr.size()); end
      @(negedge clk_i); #2;
      checks++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b0 || rfw_addr.size() != 9)
         begin failures++; $display("FAIL rstmid_wait busy=%b req=%b writes=%0d exp 1/0/9", busy_o, mem_req_o, rfw_addr.size()); end
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, mem_req_o, mem_we_o, rf_we_o} !== 5'b0 || mem_addr_o !== 32'h0 || rf_waddr_o !== 5'h0)
         begin failures++; $display("FAIL rstmid_outputs ctrl=%b addr=%h exp 0", {busy_o, done_o, mem_req_o, mem_we_o, rf_we_o}, mem_addr_o); end
      suppress_at = 0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      clear_logs();
      inject_rv = 1;
      repeat (3) @(negedge clk_i);
      #2;
      checks++;
      if (rfw_addr.size() != 0 || busy_o !== 1'b0 || done_cnt != 0)
         begin failures++; $display("FAIL rstmid_late_rvalid writes=%0d busy=%b done=%0d exp 0", rfw_addr.size(), busy_o, done_cnt); end
      start(1'b1, 1'b0, 32'h0000_2000);
      wait_done(200);
      checks++;
      if (st_addr.size() != 31 || st_addr[0] !== 32'h2000 || st_data[0] !== tb_rf[1])
         begin failures++; $display("FAIL rstmid_new_save count=%0d first=%h exp 31/00002000", st_addr.size(), st_addr.size() > 0 ? st_addr[0] : 32'h0); end
   endtask

   initial begin
      test_reset();
      test_save();
      test_restore();
      test_stall();
      test_both_req();
      test_wrap();
      test_roundtrip_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
